// File: rtl/output_arbiter.sv
// Per-output round-robin arbiter for a 2-input wormhole router port.
// The grant is held for a whole packet until its tail flit transfers.
// Accepted flits reach the output FIFO one cycle later through a registered
// write port.
module output_arbiter #(
  parameter int WIDTH = 11,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_0,
  input  logic [WIDTH-1:0] data_0,
  output logic             ready_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] data_1,
  output logic             ready_1,
  input  logic             full,
  output logic             wr_en,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_0 = 2'd1,
    LOCK_1 = 2'd2
  } state_t;

  state_t state;
  logic   ptr;   // 0: input 0 wins a tie, 1: input 1 wins a tie
  logic   xfer_0;
  logic   xfer_1;

  // Ready follows full combinationally. The output FIFO reports almost-full,
  // so the one write still in the output register always has a free slot.
  always_comb begin
    ready_0 = (state == LOCK_0) && !full;
    ready_1 = (state == LOCK_1) && !full;
    busy    = (state != IDLE);
    xfer_0  = req_0 && ready_0;
    xfer_1  = req_1 && ready_1;
  end

  // Arbitration FSM, registered write port and packet counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      wr_en     <= 1'b0;
      data_out  <= '0;
      pkt_count <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_0 && (!req_1 || !ptr)) begin
            state <= LOCK_0;
          end else if (req_1) begin
            state <= LOCK_1;
          end
        end
        LOCK_0: begin
          if (xfer_0) begin
            wr_en    <= 1'b1;
            data_out <= data_0;
            if (data_0[WIDTH-1]) begin
              state     <= IDLE;
              ptr       <= 1'b1;
              pkt_count <= pkt_count + CNT_W'(1);
            end
          end
        end
        LOCK_1: begin
          if (xfer_1) begin
            wr_en    <= 1'b1;
            data_out <= data_1;
            if (data_1[WIDTH-1]) begin
              state     <= IDLE;
              ptr       <= 1'b0;
              pkt_count <= pkt_count + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter. A second instance with a 4-bit packet
// counter shares the stimulus so counter wrap is reachable in a short run.
module tb_output_arbiter;

  localparam int WIDTH = 11;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_0 = 1'b0;
  logic [WIDTH-1:0] data_0 = '0;
  logic             req_1 = 1'b0;
  logic [WIDTH-1:0] data_1 = '0;
  logic             full = 1'b0;

  logic             ready_0, ready_1, wr_en, busy;
  logic [WIDTH-1:0] data_out;
  logic [15:0]      pkt_count;

  logic             w_ready_0, w_ready_1, w_wr_en, w_busy;
  logic [WIDTH-1:0] w_data_out;
  logic [3:0]       w_pkt_count;

  int checks = 0;
  int errors = 0;

  output_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .data_0(data_0), .ready_0(ready_0),
    .req_1(req_1), .data_1(data_1), .ready_1(ready_1),
    .full(full), .wr_en(wr_en), .data_out(data_out),
    .busy(busy), .pkt_count(pkt_count)
  );

  output_arbiter #(.WIDTH(WIDTH), .CNT_W(4)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .data_0(data_0), .ready_0(w_ready_0),
    .req_1(req_1), .data_1(data_1), .ready_1(w_ready_1),
    .full(full), .wr_en(w_wr_en), .data_out(w_data_out),
    .busy(w_busy), .pkt_count(w_pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #11;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_0", ready_0, 0);
    chk("rst_ready_1", ready_1, 0);
    chk("rst_pkt_count", pkt_count, 0);
    reset_n = 1'b1;

    // Single 3-flit packet on input 0
    req_0 = 1'b1; data_0 = 11'h005;
    tick();
    chk("p1_busy", busy, 1);
    chk("p1_ready_0", ready_0, 1);
    chk("p1_wr_idle", wr_en, 0);
    tick();
    chk("p1_wr_a", wr_en, 1);
    chk("p1_data_a", data_out, 11'h005);
    data_0 = 11'h0AA;
    tick();
    chk("p1_wr_b", wr_en, 1);
    chk("p1_data_b", data_out, 11'h0AA);
    data_0 = 11'h4FF;
    tick();
    chk("p1_wr_c", wr_en, 1);
    chk("p1_data_c", data_out, 11'h4FF);
    chk("p1_busy_end", busy, 0);
    chk("p1_ready_end", ready_0, 0);
    chk("p1_pkt", pkt_count, 1);
    req_0 = 1'b0;
    tick();
    chk("p1_wr_off", wr_en, 0);
    chk("p1_data_hold", data_out, 11'h4FF);

    // Contention from reset: input 0 first, then input 1, then input 0
    do_reset();
    req_0 = 1'b1; data_0 = 11'h011;
    req_1 = 1'b1; data_1 = 11'h021;
    tick();
    chk("c_first_r0", ready_0, 1);
    chk("c_first_r1", ready_1, 0);
    tick();
    chk("c_d011", data_out, 11'h011);
    data_0 = 11'h412;
    tick();
    chk("c_d412", data_out, 11'h412);
    chk("c_idle", busy, 0);
    data_0 = 11'h031;
    tick();
    chk("c_second_r1", ready_1, 1);
    chk("c_second_r0", ready_0, 0);
    chk("c_gap_wr", wr_en, 0);
    tick();
    chk("c_d021", data_out, 11'h021);
    data_1 = 11'h422;
    tick();
    chk("c_d422", data_out, 11'h422);
    chk("c_pkt2", pkt_count, 2);
    data_1 = 11'h041;
    tick();
    chk("c_third_r0", ready_0, 1);
    chk("c_third_r1", ready_1, 0);
    tick();
    chk("c_d031", data_out, 11'h031);
    data_0 = 11'h432;
    tick();
    chk("c_d432", data_out, 11'h432);
    chk("c_pkt3", pkt_count, 3);
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    chk("c_end_wr", wr_en, 0);
    chk("c_end_busy", busy, 0);

    // Backpressure on input 1 for 4 cycles mid-packet
    req_1 = 1'b1; data_1 = 11'h051;
    tick();
    tick();
    data_1 = 11'h052;
    tick();
    full = 1'b1;
    #1;
    chk("bp_pending_wr", wr_en, 1);
    chk("bp_pending_data", data_out, 11'h052);
    chk("bp_ready_first", ready_1, 0);
    data_1 = 11'h053;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_wr_blocked", wr_en, 0);
      chk("bp_ready_blocked", ready_1, 0);
      chk("bp_data_hold", data_out, 11'h052);
      chk("bp_busy", busy, 1);
    end
    full = 1'b0;
    #1;
    chk("bp_ready_back", ready_1, 1);
    tick();
    chk("bp_d053", data_out, 11'h053);
    chk("bp_wr_053", wr_en, 1);
    data_1 = 11'h454;
    tick();
    chk("bp_d454", data_out, 11'h454);
    chk("bp_pkt4", pkt_count, 4);
    req_1 = 1'b0;

    // Upstream bubble on input 0 while input 1 waits
    req_0 = 1'b1; data_0 = 11'h061;
    req_1 = 1'b1; data_1 = 11'h071;
    tick();
    chk("bub_r0", ready_0, 1);
    chk("bub_r1", ready_1, 0);
    tick();
    chk("bub_d061", data_out, 11'h061);
    req_0 = 1'b0; data_0 = 11'h462;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_wr", wr_en, 0);
      chk("bub_ready_1", ready_1, 0);
      chk("bub_busy", busy, 1);
      chk("bub_ready_0", ready_0, 1);
    end
    req_0 = 1'b1;
    tick();
    chk("bub_d462", data_out, 11'h462);
    chk("bub_pkt5", pkt_count, 5);
    req_0 = 1'b0;
    tick();
    chk("bub_then_r1", ready_1, 1);
    chk("bub_then_r0", ready_0, 0);
    tick();
    chk("bub_d071", data_out, 11'h071);
    data_1 = 11'h472;
    tick();
    chk("bub_d472", data_out, 11'h472);
    chk("bub_pkt6", pkt_count, 6);
    req_1 = 1'b0;

    // Asynchronous reset while locked on input 1
    req_1 = 1'b1; data_1 = 11'h081;
    tick();
    tick();
    chk("ar_pre_wr", wr_en, 1);
    chk("ar_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_wr", wr_en, 0);
    chk("ar_data", data_out, 0);
    chk("ar_ready_1", ready_1, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pkt", pkt_count, 0);
    reset_n = 1'b1;
    data_1 = 11'h082;
    req_0 = 1'b1; data_0 = 11'h091;
    tick();
    chk("ar_grant_r0", ready_0, 1);
    chk("ar_grant_r1", ready_1, 0);
    tick();
    data_0 = 11'h491;
    tick();
    chk("ar_d491", data_out, 11'h491);
    chk("ar_pkt1", pkt_count, 1);
    req_0 = 1'b0; req_1 = 1'b0;
    tick();

    // Counter wrap with back-to-back single-flit packets
    do_reset();
    req_0 = 1'b1; data_0 = 11'h400;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("wr_arb_wr", wr_en, 0);
      chk("wr_arb_busy", busy, 1);
      tick();
      chk("wr_xfer_wr", wr_en, 1);
      chk("wr_xfer_data", data_out, 11'h400);
      chk("wr_busy", busy, 0);
      chk("wr_pkt16", pkt_count, 32'(i + 1));
      chk("wr_pkt4", w_pkt_count, 32'((i + 1) % 16));
    end
    req_0 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Per-output arbitration stage in each router node, directly downstream of the two input controllers that can target this output.
- Grants the output to one input at a time, round-robin, and holds the grant for a whole wormhole packet until its tail flit passes.
- Drives a registered flit stream into the output FIFO feeding the next node.
- Flit format: bit [10] = tail, bits [9:0] = header/payload.

Parameters:
- WIDTH, 11, flit width in bits; the tail bit is bit WIDTH-1.
- CNT_W, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_0  input  1  input 0 has a valid flit for this output.
- data_0  input  WIDTH  flit from input 0.
- ready_0  output  1  this output accepts input 0's flit this cycle.
- req_1  input  1  input 1 has a valid flit for this output.
- data_1  input  WIDTH  flit from input 1.
- ready_1  output  1  this output accepts input 1's flit this cycle.
- full  input  1  output FIFO almost-full; asserted while ≤1 free entry.
- wr_en  output  1  write strobe to the output FIFO.
- data_out  output  WIDTH  flit to the output FIFO.
- busy  output  1  a packet currently holds the grant.
- pkt_count  output  CNT_W  number of tail flits forwarded since reset; wraps.

Behaviour:
- Reset: async assert on reset_n low.
  - State = IDLE.
  - Priority pointer = input 0.
  - wr_en = 0, data_out = 0, pkt_count = 0.
  - ready_0 = ready_1 = 0, busy = 0.
  - A packet in flight at reset is dropped; there is no resume.
- FSM states: IDLE, LOCK_0, LOCK_1.
- IDLE:
  - ready_0 = ready_1 = 0.
  - If only one req is high, go to that input's LOCK state.
  - If both are high, go to the LOCK state of the input named by the priority pointer.
  - If neither is high, stay.
  - Arbitration costs exactly 1 cycle.
- LOCK_x:
  - ready_x = ~full (combinational); the other ready = 0; busy = 1.
  - A transfer occurs on a cycle where req_x && ready_x.
  - The cycle after a transfer: wr_en = 1 and data_out = the accepted data_x. Latency is 1 cycle.
  - Otherwise wr_en = 0 and data_out holds its last value.
  - If the transferred flit has bit WIDTH-1 = 1:
    - next state = IDLE;
    - priority pointer moves to the other input;
    - pkt_count increments with modulo-2^CNT_W wrap.
  - req_x low mid-packet (upstream bubble): hold LOCK_x with no transfer. The grant is never released without a tail.
  - A request from the other input while locked is ignored; it never interleaves with the current packet.
- Single-flit packet (header carries the tail bit): LOCK_x for 1 cycle, then IDLE. Each packet costs at least 2 cycles; there is no back-to-back grant.
- full:
  - Sampled combinationally into ready_x.
  - The 1-cycle registered write lands in the reserved entry, so the output FIFO must define full as almost-full.
  - full asserted in the same cycle as a pending wr_en does not cancel that write.
- Simultaneous req_0 and req_1 rising in IDLE: the pointer decides.
- After reset the pointer favours input 0.
- Priority is updated only on a tail transfer, never on arbitration alone.
- busy = (state != IDLE).

Test Plan:
- Single packet on input 0 (flits 0x005, 0x0AA, 0x4FF), full=0, req_1=0:
  - IDLE→LOCK_0 one cycle after req_0;
  - ready_0 high for 3 cycles;
  - wr_en pulses 3 consecutive cycles, one cycle late, with data_out 0x005, 0x0AA, 0x4FF;
  - then IDLE, pkt_count=1.
- Contention: req_0 and req_1 asserted together from reset, each sending a 2-flit packet, held high:
  - input 0 is served first, then input 1;
  - the next pair grants input 0 again;
  - flits never interleave.
- Backpressure: full=1 for 4 cycles mid-packet:
  - ready_x=0 and no new wr_en during those cycles;
  - one pending write completes on the first full cycle;
  - the packet resumes intact when full drops.
- Upstream bubble: req_0 drops for 3 cycles between body flits while req_1 is high:
  - the grant stays on input 0;
  - ready_1 stays 0;
  - input 1 is granted only after input 0's tail.
- Wrap: preload via 65536 single-flit packets (0x400):
  - pkt_count returns to 0 and continues at 1;
  - there are 2 cycles per packet.
- Async reset mid-packet (reset_n low between clock edges in LOCK_1):
  - wr_en, data_out, ready_1, busy go to 0 immediately, without a clock edge;
  - after release the next contention grants input 0 first.
